// File: rtl/rf_write_queue.sv
// In-order write buffer feeding the register-file write port, with read bypass
// so source operands observe writes that are queued but not yet committed.
module rf_write_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     rf_we,
  input  logic                     rf_ready,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic                     byp_hit1,
  output logic [DATA_W-1:0]        byp_data1,
  output logic                     byp_hit2,
  output logic [DATA_W-1:0]        byp_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              pop;

  // Handshakes depend only on registered count, so a full queue never
  // accepts a push even when the head is leaving in the same cycle.
  assign wr_ready = (count != FULL_COUNT);
  assign rf_we    = (count != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rf_we && rf_ready;
  assign rf_waddr = entry_addr[head];
  assign rf_wdata = entry_data[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      entry_addr[tail] <= wr_addr;
      entry_data[tail] <= wr_data;
    end
  end

  // Walk valid entries oldest to youngest; later matches overwrite earlier
  // ones so the entry closest to the tail wins.
  always_comb begin : bypass_lookup
    logic [PTR_W-1:0] idx;
    idx       = '0;
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (entry_addr[idx] == rd_addr1) begin
          byp_hit1  = 1'b1;
          byp_data1 = entry_data[idx];
        end
        if (entry_addr[idx] == rd_addr2) begin
          byp_hit2  = 1'b1;
          byp_data2 = entry_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench for rf_write_queue: a queue-based reference model predicts
// every output each cycle and checks commits in arrival order.
module tb_rf_write_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rf_we;
  logic              rf_ready;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              byp_hit1;
  logic [DATA_W-1:0] byp_data1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data2;
  logic [2:0]        count;

  entry_t sb[$];
  int     checks    = 0;
  int     failures  = 0;
  int     commits   = 0;
  bit     checks_on = 1'b0;

  rf_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rf_we(rf_we), .rf_ready(rf_ready), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t modelBypass(input logic [ADDR_W-1:0] a, output bit hit);
    hit = 1'b0;
    modelBypass = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].addr == a) begin
        hit = 1'b1;
        modelBypass = sb[i];
        break;
      end
    end
  endfunction

  task automatic applyStimulus(input bit v, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input bit rdy,
                               input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    rf_ready = rdy;
    rd_addr1 = r1;
    rd_addr2 = r2;
  endtask

  // Compare all outputs against the model mid-cycle, then advance one edge
  // and update the model with whatever handshakes the model predicts.
  task automatic checkOutput(input string tag);
    bit     do_push, do_pop, h1, h2;
    entry_t b1, b2;
    @(negedge clk);
    do_pop  = rf_ready && (sb.size() != 0);
    do_push = wr_valid && (sb.size() != DEPTH);
    if (checks_on) begin
      b1 = modelBypass(rd_addr1, h1);
      b2 = modelBypass(rd_addr2, h2);
      expectEq({tag, "_count"}, 64'(count), 64'(sb.size()));
      expectEq({tag, "_wr_ready"}, 64'(wr_ready), 64'(sb.size() != DEPTH));
      expectEq({tag, "_rf_we"}, 64'(rf_we), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        expectEq({tag, "_rf_waddr"}, 64'(rf_waddr), 64'(sb[0].addr));
        expectEq({tag, "_rf_wdata"}, 64'(rf_wdata), 64'(sb[0].data));
      end
      expectEq({tag, "_byp_hit1"}, 64'(byp_hit1), 64'(h1));
      expectEq({tag, "_byp_data1"}, 64'(byp_data1), 64'(b1.data));
      expectEq({tag, "_byp_hit2"}, 64'(byp_hit2), 64'(h2));
      expectEq({tag, "_byp_data2"}, 64'(byp_data2), 64'(b2.data));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
    end else begin
      if (do_pop) begin
        void'(sb.pop_front());
        commits++;
      end
      if (do_push) sb.push_back('{addr: wr_addr, data: wr_data});
    end
  endtask

  initial begin
    int base;
    $display("[TB] starting rf_write_queue bench");
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reset0");
    checkOutput("reset1");
    rst = 1'b0;
    checks_on = 1'b1;
    checkOutput("idle");
    expectEq("idle_rf_we_const", 64'(rf_we), 64'd0);

    // Single entry held while the register file stalls
    applyStimulus(1, 4'd3, 32'hDEADBEEF, 0, 4'd3, 4'd0);
    checkOutput("push1");
    applyStimulus(0, 0, 0, 0, 4'd3, 4'd0);
    expectEq("push1_waddr_const", 64'(rf_waddr), 64'd3);
    expectEq("push1_wdata_const", 64'(rf_wdata), 64'hDEADBEEF);
    for (int i = 0; i < 3; i++) checkOutput("hold1");
    applyStimulus(0, 0, 0, 1, 4'd3, 4'd0);
    checkOutput("pop1");
    expectEq("pop1_count_const", 64'(count), 64'd0);

    // Fill to full, hold a fifth request, then drain in order
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, ADDR_W'(i), DATA_W'(i * 32'h11), 0, 4'd2, 4'd4);
      checkOutput("fill");
    end
    expectEq("full_wr_ready_const", 64'(wr_ready), 64'd0);
    applyStimulus(1, 4'd9, 32'h99, 0, 4'd2, 4'd4);
    checkOutput("held5a");
    checkOutput("held5b");
    applyStimulus(1, 4'd9, 32'h99, 1, 4'd2, 4'd9);
    checkOutput("drain_full");
    checkOutput("accept5");
    applyStimulus(0, 0, 0, 1, 4'd2, 4'd9);
    for (int i = 0; i < 5; i++) checkOutput("drain");
    expectEq("drain_empty", 64'(count), 64'd0);

    // Bypass: youngest duplicate wins, unmatched port reads zero
    applyStimulus(1, 4'd5, 32'hA, 0, 4'd5, 4'd7);
    checkOutput("byp_push_a");
    applyStimulus(1, 4'd5, 32'hB, 0, 4'd5, 4'd7);
    checkOutput("byp_push_b");
    applyStimulus(1, 4'd6, 32'hC, 0, 4'd5, 4'd7);
    checkOutput("byp_push_c");
    applyStimulus(0, 0, 0, 0, 4'd5, 4'd7);
    checkOutput("byp_look");
    expectEq("byp_data1_const", 64'(byp_data1), 64'hB);
    applyStimulus(0, 0, 0, 1, 4'd5, 4'd5);
    checkOutput("byp_pop_a");
    checkOutput("byp_pop_b");
    expectEq("byp_gone_const", 64'(byp_hit1), 64'd0);
    checkOutput("byp_pop_c");

    // Streaming push+pop every cycle across pointer wrap
    base = commits;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, ADDR_W'(i), DATA_W'(i * 32'h101), 1, ADDR_W'(i), ADDR_W'(i));
      checkOutput("stream");
    end
    applyStimulus(0, 0, 0, 1, 4'd9, 4'd0);
    checkOutput("stream_tail");
    expectEq("stream_commits", 64'(commits - base), 64'd10);

    // Reset with pending entries and a request on the input
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, ADDR_W'(i + 10), DATA_W'(i + 32'h500), 0, 4'd10, 4'd15);
      checkOutput("pre_rst");
    end
    rst = 1'b1;
    applyStimulus(1, 4'd15, 32'h1234, 0, 4'd10, 4'd15);
    checkOutput("in_rst");
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 4'd10, 4'd15);
    checkOutput("post_rst");
    expectEq("post_rst_rf_we_const", 64'(rf_we), 64'd0);
    checkOutput("post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
- Write-request buffer directly upstream of the register file.
- Accepts register write requests (address + 32-bit data) from the execute/memory stages and drains them into the register-file write port in order, one per cycle.
- Provides read-bypass so source-operand reads see writes still queued and not yet committed.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 4, register address width (16 registers).
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  producer has a write request.
- wr_ready  output  1  queue can accept a request this cycle.
- wr_addr  input  ADDR_W  destination register of the request.
- wr_data  input  DATA_W  data of the request.
- rf_we  output  1  head entry valid; drives the register-file write enable.
- rf_ready  input  1  register file commits the presented write this cycle.
- rf_waddr  output  ADDR_W  head entry address.
- rf_wdata  output  DATA_W  head entry data.
- rd_addr1  input  ADDR_W  source operand 1 address for bypass lookup.
- rd_addr2  input  ADDR_W  source operand 2 address for bypass lookup.
- byp_hit1  output  1  a queued entry matches rd_addr1.
- byp_data1  output  DATA_W  data of the youngest matching entry for rd_addr1.
- byp_hit2  output  1  a queued entry matches rd_addr2.
- byp_data2  output  DATA_W  data of the youngest matching entry for rd_addr2.
- count  output  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - rst sampled on the rising edge of clk; it clears head/tail pointers and count to 0.
  - After reset: rf_we=0, wr_ready=1, byp_hit1/2=0, byp_data1/2=0.
  - Entry storage need not be cleared.
  - Reset mid-operation discards all pending entries; no write is presented to the register file in the cycle after reset.
- Push
  - Occurs when wr_valid && wr_ready.
  - The entry is written at the tail and the tail pointer increments modulo DEPTH.
- Pop
  - Occurs when rf_we && rf_ready.
  - The head pointer increments modulo DEPTH.
- Outputs derived from state
  - wr_ready = (count != DEPTH). It depends only on registered state, never on rf_ready in the same cycle; a full queue rejects a push even if a pop occurs that cycle.
  - rf_we = (count != 0).
  - rf_waddr and rf_wdata are combinational from the head entry.
  - When empty, rf_waddr and rf_wdata are don't-care but must not produce X on rf_we.
- Count update
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, both pointers advance.
  - Pop on empty is impossible (rf_we=0).
  - Push on full is ignored; the producer must hold wr_valid and data until wr_ready.
- Latency
  - A request pushed in cycle N is presented on rf_we earliest in cycle N+1.
  - There is no combinational wr_* to rf_* path.
- Ordering
  - Strict FIFO.
  - Multiple writes to the same address commit in arrival order.
- Bypass
  - Purely combinational over entries valid at the start of the cycle, including the head being popped this cycle.
  - The youngest match (closest to tail) wins.
  - No match: hit=0 and data=0.
  - A request being pushed in the same cycle is not visible to bypass until the next cycle.
  - Ports 1 and 2 are independent; identical addresses give identical results.
- Pointer wrap-around: head/tail wrap to 0 after DEPTH-1; full versus empty is resolved by count, not by pointer equality.
- Address 0 is not special; it is queued like any other register.

Test Plan:
- Reset then idle → count=0, rf_we=0, wr_ready=1, byp_hit1=byp_hit2=0.
- Push (addr 3, 0xDEADBEEF) with rf_ready=0 → next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF, count=1. Hold 3 cycles, then rf_ready=1 → pops, count=0.
- Fill 4 entries (addr 1..4, data 0x11..0x44) with rf_ready=0 → wr_ready=0, count=4; a 5th request is held, not accepted. Raise rf_ready → drains in order 1,2,3,4; the 5th is accepted the cycle after wr_ready returns to 1.
- Queue (addr 5, 0xA), (addr 5, 0xB), (addr 6, 0xC); rd_addr1=5, rd_addr2=7 → byp_hit1=1, byp_data1=0xB, byp_hit2=0, byp_data2=0. After both addr-5 entries pop → byp_hit1=0.
- Continuous push and pop every cycle for 10 cycles across pointer wrap, addresses 0..9, data=addr*0x101 → count stays 1, register file receives all 10 in order with correct data.
- 3 entries queued, assert rst for 1 cycle while wr_valid=1 → next cycle count=0, rf_we=0; the request presented during reset is not stored.
